// File: rtl/joy_serial_scan.sv
// Serial joystick scanner: clocks a parallel-in/serial-out button chain, then
// debounces whole frames before publishing the button state.
module joy_serial_scan #(
  parameter int PLAYERS    = 2,
  parameter int BITS       = 12,
  parameter int CLK_DIV    = 16,
  parameter int DEBOUNCE   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    joy_data,
  output logic                    joy_load,
  output logic                    joy_clk,
  output logic [PLAYERS*BITS-1:0] joystick,
  output logic                    frame_done
);

  localparam int NB    = PLAYERS * BITS;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NB);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [2:0]       DEB_MIN  = 3'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_UPDATE
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       sync_q;
  logic [IDX_W-1:0] idx_q;
  logic [NB-1:0]    capture_q;
  logic [NB-1:0]    prev_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [NB-1:0]    joystick_q;
  logic             joy_load_q;
  logic             joy_clk_q;
  logic             frame_done_q;
  logic             tick;

  // Free-running divider; only reset realigns the tick phase.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], joy_data};
    end
  end

  always_comb begin
    stable_d = stable_q;
    if (capture_q != prev_q) begin
      stable_d = 3'd1;
    end else if (stable_q != 3'd7) begin
      stable_d = stable_q + 3'd1;
    end
  end

  // Strobes are registered and change on the same edge as the state they belong to.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      capture_q    <= '0;
      prev_q       <= '0;
      stable_q     <= 3'd0;
      joystick_q   <= '0;
      joy_load_q   <= 1'b1;
      joy_clk_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick && enable) begin
            state_q    <= S_LOAD;
            joy_load_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (tick) begin
            state_q    <= S_LOW;
            joy_load_q <= 1'b1;
            idx_q      <= '0;
          end
        end
        S_LOW: begin
          if (tick) begin
            capture_q[idx_q] <= sync_q[1];
            state_q          <= S_HIGH;
            joy_clk_q        <= 1'b1;
          end
        end
        S_HIGH: begin
          if (tick) begin
            joy_clk_q <= 1'b0;
            if (idx_q == IDX_LAST) begin
              state_q      <= S_UPDATE;
              frame_done_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_LOW;
            end
          end
        end
        S_UPDATE: begin
          stable_q <= stable_d;
          prev_q   <= capture_q;
          if (stable_d >= DEB_MIN) begin
            joystick_q <= (ACTIVE_LOW != 0) ? ~capture_q : capture_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign joy_load   = joy_load_q;
  assign joy_clk    = joy_clk_q;
  assign joystick   = joystick_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/joy_serial_scan.md
JOY_SERIAL_SCAN -- requirements
Module: joy_serial_scan

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of players chained on the serial link (1-4).
REQ-002 SHALL have parameter BITS, default 12, number of bits per player (4-16).
REQ-003 SHALL have parameter CLK_DIV, default 16, number of clk_sys cycles per scan tick (minimum 4).
REQ-004 SHALL have parameter DEBOUNCE, default 2, number of identical consecutive frames required before the output updates (1-7).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1; when 1, the output is the inversion of the captured line levels.
REQ-006 SHALL have port clk_sys, input, 1 bit: single clock for all logic.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit: permits the start of new frames.
REQ-009 SHALL have port joy_data, input, 1 bit: serial data from the shift-register chain; asynchronous to clk_sys.
REQ-010 SHALL have port joy_load, output, 1 bit: active-low parallel-load strobe to the chain.
REQ-011 SHALL have port joy_clk, output, 1 bit: shift clock to the chain.
REQ-012 SHALL have port joystick, output, PLAYERS*BITS bits: debounced button state; player p occupies bits [p*BITS +: BITS].
REQ-013 SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of each frame.

Function
REQ-014 SHALL generate a one-cycle internal tick every CLK_DIV clk_sys cycles from a free-running counter that is cleared only by reset.
REQ-015 SHALL pass joy_data through a two-flop synchronizer; every sample SHALL use the synchronized value.
REQ-016 SHALL implement a scan FSM with the states IDLE, LOAD, LOW, HIGH and UPDATE; all state transitions except UPDATE->IDLE SHALL occur only on a tick.
REQ-017 In IDLE, on a tick with enable=1, the FSM SHALL go to LOAD; with enable=0 it SHALL stay in IDLE.
REQ-018 In LOAD, joy_load SHALL be 0 for exactly one tick period; on the next tick the FSM SHALL clear the bit index and go to LOW.
REQ-019 In LOW, joy_clk SHALL be 0; on the tick the FSM SHALL store the synchronized data into capture[bit index] and go to HIGH.
REQ-020 In HIGH, joy_clk SHALL be 1; on the tick, if bit index = PLAYERS*BITS-1, the FSM SHALL go to UPDATE, otherwise it SHALL increment the bit index and go to LOW.
REQ-021 The first bit shifted out SHALL land in capture[0], and the last bit in capture[PLAYERS*BITS-1].
REQ-022 UPDATE SHALL last exactly one clk_sys cycle; frame_done SHALL be 1 in that cycle, and the FSM SHALL then go to IDLE.
REQ-023 In UPDATE, stable_cnt SHALL become 1 if capture differs from prev_capture, otherwise stable_cnt+1 saturating at 7; prev_capture SHALL load capture.
REQ-024 In UPDATE, if the new stable_cnt is at least DEBOUNCE, joystick SHALL load capture (inverted when ACTIVE_LOW=1), visible the cycle after frame_done; otherwise joystick SHALL hold its value.
REQ-025 With enable held at 1, the frame period SHALL be (2+2*PLAYERS*BITS)*CLK_DIV cycles.
REQ-026 Deasserting enable mid-frame SHALL NOT abort the frame; the frame SHALL complete, including UPDATE, and no new LOAD SHALL follow.
REQ-027 joy_load SHALL be 1 in all states except LOAD, and joy_clk SHALL be 0 in all states except HIGH.

Reset
REQ-028 On reset=1, asynchronously: state=IDLE, tick counter=0, bit index=0, capture=0, prev_capture=0, stable_cnt=0, synchronizer=0, joystick=0, frame_done=0, joy_load=1, joy_clk=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial capture; after release, the first frame SHALL start with a LOAD on the first tick at which enable=1.

Verification
REQ-030 Reset value check: assert reset with enable=1 -> joystick=0, joy_load=1, joy_clk=0, frame_done=0; release -> joy_load goes low at cycle CLK_DIV.
REQ-031 Timing and order check with PLAYERS=1, BITS=4, CLK_DIV=4, DEBOUNCE=1, ACTIVE_LOW=0, serial bits 1,0,1,1 -> joy_load low for 4 cycles, 4 joy_clk pulses each 4 cycles high, joystick=4'b1101, frame_done period 40 cycles.
REQ-032 Inversion check with the default parameters (PLAYERS=2, BITS=12) and joy_data held at 0 -> joystick=24'hFFFFFF after the second frame; frame period 800 cycles.
REQ-033 Debounce check with DEBOUNCE=2: frames A, A, B, A with A=24'h000000 and B=24'h000001 -> joystick becomes ~A after frame 2 and remains ~A through frame 4 (the B glitch is rejected).
REQ-034 Enable drop check: drop enable during bit 5 of a frame -> the frame completes with one frame_done, and joy_load then stays 1 for at least 3 frame periods.
REQ-035 Reset mid-frame check: assert reset during HIGH of bit 10 -> joy_clk=0 immediately and joystick=0; after release, a full 24-bit frame with a correct result follows.
